// File: rtl/stream_sequencer.sv
// rtl/stream_sequencer.sv - segmented memory-to-stream sequencer with capture port
module stream_sequencer #(
  parameter int DATA_W  = 16,
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int NUM_SEG = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_SEG*ADDR_W-1:0] seg_base,
  input  logic [NUM_SEG*ADDR_W-1:0] seg_len,
  input  logic [NUM_SEG-1:0]        seg_split,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic                      out_vld,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_rdy,
  input  logic                      sink_vld,
  input  logic [DATA_W-1:0]         sink_data,
  output logic                      sink_rdy,
  input  logic [ADDR_W-1:0]         cap_base,
  input  logic [ADDR_W-1:0]         cap_expect,
  output logic                      cap_we,
  output logic [ADDR_W-1:0]         cap_addr,
  output logic [DATA_W-1:0]         cap_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         cap_cnt
);
  localparam int BEATS  = WORD_W / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SEG_W  = $clog2(NUM_SEG + 1);
  localparam logic [SEG_W-1:0] SEG_NONE = SEG_W'(NUM_SEG);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STREAM, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [NUM_SEG*ADDR_W-1:0] r_seg_base, r_seg_len;
  logic [NUM_SEG-1:0]        r_seg_split;
  logic [ADDR_W-1:0]         r_cap_base, r_cap_expect;

  logic              r_rd_active, r_rd_split, r_pend, r_pend_split;
  logic [SEG_W-1:0]  r_rd_seg;
  logic [ADDR_W-1:0] r_rd_addr, r_rd_left;

  logic [WORD_W-1:0] r_buf_word [2];
  logic [1:0]        r_buf_split, r_cnt;
  logic              r_wr_ptr, r_rd_ptr;
  logic [BEAT_W-1:0] r_beat;

  logic              r_cap_we;
  logic [ADDR_W-1:0] r_cap_cnt, r_cap_addr;
  logic [DATA_W-1:0] r_cap_wdata;

  logic              w_clear, w_start, w_have_head, w_head_split, w_last_beat;
  logic              w_fire, w_pop, w_push, w_deq;
  logic [1:0]        w_cnt_next;
  logic [WORD_W-1:0] w_head_word;
  logic [SEG_W-1:0]  w_start_seg, w_adv_seg, w_start_sel, w_adv_sel;

  // First segment at or after 'from' with a non-zero length, SEG_NONE if none
  function automatic logic [SEG_W-1:0] f_first_seg(input logic [NUM_SEG*ADDR_W-1:0] lens,
                                                   input int from);
    logic [SEG_W-1:0] idx;
    idx = SEG_NONE;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (i >= from && lens[i*ADDR_W +: ADDR_W] != '0) idx = SEG_W'(i);
    end
    return idx;
  endfunction

  // Datapath control: read issue, output head selection (bypasses the buffer when empty)
  always_comb begin
    w_clear      = !rst_n || abort;
    w_start      = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
    w_start_seg  = f_first_seg(seg_len, 0);
    w_adv_seg    = f_first_seg(r_seg_len, int'(r_rd_seg) + 1);
    w_start_sel  = (w_start_seg == SEG_NONE) ? '0 : w_start_seg;
    w_adv_sel    = (w_adv_seg == SEG_NONE) ? '0 : w_adv_seg;
    w_have_head  = (r_cnt != 2'd0) || r_pend;
    w_head_word  = (r_cnt != 2'd0) ? r_buf_word[r_rd_ptr] : mem_rdata;
    w_head_split = (r_cnt != 2'd0) ? r_buf_split[r_rd_ptr] : r_pend_split;
    w_last_beat  = !w_head_split || (r_beat == BEAT_W'(BEATS - 1));
    out_vld      = (r_state == S_STREAM) && w_have_head;
    w_fire       = out_vld && out_rdy;
    w_pop        = w_fire && w_last_beat;
    w_push       = r_pend && !((r_cnt == 2'd0) && w_pop);
    w_deq        = w_pop && (r_cnt != 2'd0);
    w_cnt_next   = r_cnt + {1'b0, w_push} - {1'b0, w_deq};
    mem_rd_en    = (r_state == S_FETCH || r_state == S_STREAM) && r_rd_active &&
                   (w_cnt_next <= 2'd1);
    mem_addr     = mem_rd_en ? r_rd_addr : '0;
    out_data     = out_vld ? w_head_word[int'(r_beat)*DATA_W +: DATA_W] : '0;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_next = S_FETCH;
      S_FETCH:  w_state_next = r_rd_active ? S_STREAM : S_DRAIN;
      S_STREAM: if (!r_rd_active && w_pop && w_cnt_next == 2'd0) w_state_next = S_DRAIN;
      S_DRAIN:  if (r_cap_cnt == r_cap_expect) w_state_next = S_DONE;
      S_DONE:   if (w_start) w_state_next = S_FETCH;
      default:  w_state_next = S_IDLE;
    endcase
    if (abort) w_state_next = S_IDLE;
    busy     = (r_state == S_FETCH) || (r_state == S_STREAM) || (r_state == S_DRAIN);
    done     = (r_state == S_DONE);
    sink_rdy = busy;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Run configuration captured at start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_base   <= '0;
      r_seg_len    <= '0;
      r_seg_split  <= '0;
      r_cap_base   <= '0;
      r_cap_expect <= '0;
    end else if (w_start) begin
      r_seg_base   <= seg_base;
      r_seg_len    <= seg_len;
      r_seg_split  <= seg_split;
      r_cap_base   <= cap_base;
      r_cap_expect <= cap_expect;
    end
  end

  // Read walker: steps through words, hopping straight over empty segments
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_rd_active  <= 1'b0;
      r_rd_seg     <= '0;
      r_rd_addr    <= '0;
      r_rd_left    <= '0;
      r_rd_split   <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_split <= 1'b0;
    end else begin
      r_pend <= mem_rd_en;
      if (mem_rd_en) r_pend_split <= r_rd_split;
      if (w_start) begin
        r_rd_active <= (w_start_seg != SEG_NONE);
        r_rd_seg    <= w_start_seg;
        r_rd_addr   <= seg_base[int'(w_start_sel)*ADDR_W +: ADDR_W];
        r_rd_left   <= seg_len[int'(w_start_sel)*ADDR_W +: ADDR_W];
        r_rd_split  <= seg_split[w_start_sel];
      end else if (mem_rd_en) begin
        if (r_rd_left == ADDR_W'(1)) begin
          r_rd_active <= (w_adv_seg != SEG_NONE);
          r_rd_seg    <= w_adv_seg;
          r_rd_addr   <= r_seg_base[int'(w_adv_sel)*ADDR_W +: ADDR_W];
          r_rd_left   <= r_seg_len[int'(w_adv_sel)*ADDR_W +: ADDR_W];
          r_rd_split  <= r_seg_split[w_adv_sel];
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
          r_rd_left <= r_rd_left - ADDR_W'(1);
        end
      end
    end
  end

  // Two-word prefetch buffer and beat index within the head word
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
      r_beat      <= '0;
      r_buf_split <= '0;
    end else begin
      if (w_push) begin
        r_buf_word[r_wr_ptr]  <= mem_rdata;
        r_buf_split[r_wr_ptr] <= r_pend_split;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= w_cnt_next;
      if (w_pop)       r_beat <= '0;
      else if (w_fire) r_beat <= r_beat + BEAT_W'(1);
    end
  end

  // Capture port: one registered write per accepted sink beat, saturating count
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_cap_we    <= 1'b0;
      r_cap_cnt   <= '0;
      r_cap_addr  <= '0;
      r_cap_wdata <= '0;
    end else begin
      r_cap_we <= sink_vld && sink_rdy;
      if (sink_vld && sink_rdy) begin
        r_cap_addr  <= r_cap_base + r_cap_cnt;
        r_cap_wdata <= sink_data;
        if (r_cap_cnt != '1) r_cap_cnt <= r_cap_cnt + ADDR_W'(1);
      end
      if (w_start) r_cap_cnt <= '0;
    end
  end

  assign cap_we    = r_cap_we;
  assign cap_addr  = r_cap_addr;
  assign cap_wdata = r_cap_wdata;
  assign cap_cnt   = r_cap_cnt;
endmodule
